// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data memory.
// Holds the access-size encodings, the controller state type and the lane count.
// No ports: imported by byte_data_memory and mem_lane_extract.
package mem_pkg;

    // Access size as carried on Size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte lanes per 32-bit word
    localparam int LANES = 4;

    // CLEAR zeroes the array after reset; RUN serves requests
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/mem_lane_extract.sv
// Load formatter: picks the addressed byte/halfword out of a word and extends it.
// Ports: word (registered array word), lane (Address[1:0]), size (access size),
//        sign_ext (1 = sign-extend), data (right-aligned, extended result).
module mem_lane_extract
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{lane, 3'b000} +: 8];
        // Halfwords are aligned, so only lane[1] selects the upper or lower half
        sel_half = lane[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (size)
            SZ_BYTE: data = sign_ext ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
            SZ_HALF: data = sign_ext ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable 32-bit data memory with one-cycle request/response handshake.
// Ports: CLK, RESET (sync, active-high); request Req/MemWrite/Size/Signed/Address/WriteData;
//        response Ready (accepting), Ack (one-cycle pulse), Err, ReadData (extended load data).
module byte_data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Ready,
    output logic        Ack,
    output logic        Err,
    output logic [31:0] ReadData
);

    localparam int ADDR_HI = IDX_W + 2;

    state_t             state;
    logic [IDX_W-1:0]   clr_cnt;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               req_err;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic [31:0]        wr_data;
    logic [LANES-1:0]   wr_be;

    // Response registers
    logic               ack_q;
    logic               err_q;
    logic               ld_q;
    logic [31:0]        rd_word;
    logic [1:0]         rd_lane;
    logic [1:0]         rd_size;
    logic               rd_sgn;
    logic [31:0]        ext_data;

    assign idx    = Address[IDX_W+1:2];
    assign lane   = Address[1:0];
    // RESET masks Ready at once so nothing is accepted in a reset cycle
    assign Ready  = (state == ST_RUN) && !RESET;
    assign accept = Req && Ready;

    always_comb begin
        req_err = (Address[31:ADDR_HI] != '0);
        case (Size)
            SZ_BYTE: begin end
            SZ_HALF: if (Address[0]) req_err = 1'b1;
            SZ_WORD: if (Address[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // Replicate store data across lanes so the byte enables alone pick the target
    always_comb begin
        wr_data = WriteData;
        wr_be   = '0;
        case (Size)
            SZ_BYTE: begin
                wr_data = {4{WriteData[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            SZ_HALF: begin
                wr_data = {2{WriteData[15:0]}};
                wr_be   = Address[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = '0;
        endcase
    end

    // Array write port: clear sweep in CLEAR, byte-enabled stores in RUN
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (accept && MemWrite && !req_err) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_be[l]) mem[idx][8*l +: 8] <= wr_data[8*l +: 8];
                end
            end
        end
    end

    // Controller FSM, clear counter and response registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            rd_word <= '0;
            rd_lane <= '0;
            rd_size <= '0;
            rd_sgn  <= 1'b0;
        end else begin
            ack_q <= accept;
            err_q <= accept && req_err;
            ld_q  <= accept && !MemWrite && !req_err;
            if (accept && !MemWrite) begin
                rd_word <= mem[idx];
                rd_lane <= lane;
                rd_size <= Size;
                rd_sgn  <= Signed;
            end
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH - 1)) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    mem_lane_extract u_extract (
        .word     (rd_word),
        .lane     (rd_lane),
        .size     (rd_size),
        .sign_ext (rd_sgn),
        .data     (ext_data)
    );

    // A response pending when RESET rises is dropped immediately
    assign Ack      = ack_q && !RESET;
    assign Err      = err_q && !RESET;
    assign ReadData = (ld_q && !RESET) ? ext_data : '0;

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: byte-array reference model checked every cycle,
// plus directed accesses with hand-computed expected values.
module tb_byte_data_memory;

    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Req = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Signed = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        Ready;
    logic        Ack;
    logic        Err;
    logic [31:0] ReadData;

    int total = 0;
    int bad = 0;

    byte_data_memory #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Req       (Req),
        .MemWrite  (MemWrite),
        .Size      (Size),
        .Signed    (Signed),
        .Address   (Address),
        .WriteData (WriteData),
        .Ready     (Ready),
        .Ack       (Ack),
        .Err       (Err),
        .ReadData  (ReadData)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // ---------------- reference model: flat byte array ----------------
    logic [7:0]  m [DEPTH*4];
    bit          m_ready = 1'b0;
    int          since_rst = 0;
    logic        e_ack = 1'b0;
    logic        e_err = 1'b0;
    logic [31:0] e_rd = '0;

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return a >= 32'(DEPTH * 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        int v;
        if (sz == 2'd0) begin
            v = int'(m[a]);
            if (sg && v >= 128) v -= 256;
            return 32'(v);
        end
        if (sz == 2'd1) begin
            v = int'(m[a]) + 256 * int'(m[a+1]);
            if (sg && v >= 32768) v -= 65536;
            return 32'(v);
        end
        return {m[a+3], m[a+2], m[a+1], m[a]};
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) m[a+i] = wd[8*i +: 8];
    endtask

    // Compare process: inputs change only on negedges, so at posedge+1 they
    // still hold the values the DUT sampled at that edge.
    always begin
        @(posedge CLK);
        #1;
        if (RESET) begin
            since_rst = 0;
            m_ready = 1'b0;
            e_ack = 1'b0;
            e_err = 1'b0;
            e_rd = '0;
        end else begin
            e_ack = Req && m_ready;
            e_err = 1'b0;
            e_rd = '0;
            if (e_ack) begin
                if (model_err(Size, Address)) e_err = 1'b1;
                else if (MemWrite) model_store(Size, Address, WriteData);
                else e_rd = model_load(Size, Signed, Address);
            end
            if (!m_ready) begin
                since_rst++;
                if (since_rst == DEPTH) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH * 4; i++) m[i] = 8'h00;
                end
            end
        end
        chk("cyc_ready", 32'(Ready), 32'(m_ready));
        chk("cyc_ack", 32'(Ack), 32'(e_ack));
        if (e_ack) begin
            chk("cyc_err", 32'(Err), 32'(e_err));
            chk("cyc_rdata", ReadData, e_rd);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic access(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic ack, output logic err, output logic [31:0] rd);
        @(negedge CLK);
        Req = 1'b1; MemWrite = we; Size = sz; Signed = sg; Address = a; WriteData = wd;
        @(negedge CLK);
        Req = 1'b0;
        ack = Ack; err = Err; rd = ReadData;
    endtask

    task automatic ld(input string name, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err);
        logic ack, err;
        logic [31:0] rd;
        access(1'b0, sz, sg, a, 32'h0, ack, err, rd);
        chk({name, "_ack"}, 32'(ack), 32'd1);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_rd"}, rd, exp_rd);
    endtask

    task automatic st(input string name, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_err);
        logic ack, err;
        logic [31:0] rd;
        access(1'b1, sz, 1'b0, a, wd, ack, err, rd);
        chk({name, "_ack"}, 32'(ack), 32'd1);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_rd"}, rd, 32'h0);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (!Ready && cyc < 200);
    endtask

    initial begin
        int cyc;
        int acks;
        int nz;
        logic ack, err;
        logic [31:0] rd;

        // Reset: 3-cycle pulse, Ready after exactly DEPTH cycles, memory zero
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        wait_ready(cyc);
        chk("rst_ready_delay", 32'(cyc), 32'd64);
        ld("rst_w0", 2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        ld("rst_w31", 2'd2, 1'b0, 32'h0000_007C, 32'h0000_0000, 1'b0);
        ld("rst_w63", 2'd2, 1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0);

        // Byte lanes
        st("lane_sw", 2'd2, 32'h10, 32'h1122_3344, 1'b0);
        st("lane_sb", 2'd0, 32'h12, 32'hFFFF_FFAB, 1'b0);
        ld("lane_lb", 2'd0, 1'b1, 32'h12, 32'hFFFF_FFAB, 1'b0);
        ld("lane_lhu", 2'd1, 1'b0, 32'h12, 32'h0000_11AB, 1'b0);
        ld("lane_lw", 2'd2, 1'b0, 32'h10, 32'h11AB_3344, 1'b0);
        ld("lane_lbu0", 2'd0, 1'b0, 32'h10, 32'h0000_0044, 1'b0);
        st("lane_sh", 2'd1, 32'h22, 32'h1234_BEEF, 1'b0);
        ld("lane_lh", 2'd1, 1'b1, 32'h22, 32'hFFFF_BEEF, 1'b0);
        ld("lane_lbu3", 2'd0, 1'b0, 32'h23, 32'h0000_00BE, 1'b0);
        ld("lane_lw2", 2'd2, 1'b1, 32'h20, 32'hBEEF_0000, 1'b0);

        // Errors
        ld("err_lh_odd", 2'd1, 1'b0, 32'h01, 32'h0, 1'b1);
        st("err_sw_mis", 2'd2, 32'h06, 32'hDEAD_BEEF, 1'b1);
        ld("err_size3", 2'd3, 1'b0, 32'h10, 32'h0, 1'b1);
        ld("err_range", 2'd2, 1'b0, 32'h100, 32'h0, 1'b1);
        ld("err_nochg", 2'd2, 1'b0, 32'h04, 32'h0000_0000, 1'b0);
        ld("err_keep", 2'd2, 1'b0, 32'h10, 32'h11AB_3344, 1'b0);

        // Throughput: 8 store/load pairs back to back on word 0x40
        acks = 0;
        @(negedge CLK);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0 && Ack) acks++;
            if (i >= 2 && (i % 2) == 0)
                chk("thru_ld", ReadData, 32'hC0DE_0000 | 32'((i - 2) / 2));
            if (i < 16) begin
                Req = 1'b1;
                MemWrite = ((i % 2) == 0);
                Size = 2'd2;
                Signed = 1'b0;
                Address = 32'h40;
                WriteData = 32'hC0DE_0000 | 32'(i / 2);
                @(negedge CLK);
            end else begin
                Req = 1'b0;
            end
        end
        chk("thru_acks", 32'(acks), 32'd16);

        // Reset mid-operation: drop the pending load, restart a clear halfway
        st("mid_pre", 2'd2, 32'h14, 32'hFFFF_FFFF, 1'b0);
        @(negedge CLK);
        Req = 1'b1; MemWrite = 1'b0; Size = 2'd2; Address = 32'h14;
        @(negedge CLK);
        Req = 1'b0;
        RESET = 1'b1;
        #1;
        chk("mid_drop_ack", 32'(Ack), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (32) @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        wait_ready(cyc);
        chk("mid_ready_delay", 32'(cyc), 32'd64);
        nz = 0;
        for (int w = 0; w < DEPTH; w++) begin
            access(1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0, ack, err, rd);
            if (!ack || err || rd != 32'h0) nz++;
        end
        chk("mid_all_zero", 32'(nz), 32'd0);

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
